regfile_wb_arbiter: RTL and testbench

//  Shares the single regfile write port (write/address_dest/write_data) between ALU and MEM

---
 rtl/regfile_wb_arbiter_pkg.sv | 12 +
 rtl/regfile_wb_arbiter_grant.sv | 16 +
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int WORD_W           = 32;
  localparam int DEF_SIZE         = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_t;
endpackage

// File: rtl/regfile_wb_arbiter_grant.sv
// Combinational grant select: MEM has fixed priority unless ALU has starved.
module wb_grant
  import regfile_wb_arbiter_pkg::*;
(
  input  logic   alu_valid,
  input  logic   mem_valid,
  input  logic   starved,
  output grant_t gnt
);
  always_comb begin
    gnt = GNT_NONE;
    if (alu_valid && mem_valid) gnt = starved ? GNT_ALU : GNT_MEM;
    else if (mem_valid)         gnt = GNT_MEM;
    else if (alu_valid)         gnt = GNT_ALU;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter between ALU and MEM writeback, with a
// pending-write scoreboard for decode stalls and a sticky protocol error.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int SIZE         = DEF_SIZE,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int BITS        = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [BITS-1:0]   alu_dest,
  input  logic [WORD_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [BITS-1:0]   mem_dest,
  input  logic [WORD_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [BITS-1:0]   issue_dest,
  output logic              rf_write,
  output logic [BITS-1:0]   rf_dest,
  output logic [WORD_W-1:0] rf_data,
  output logic [SIZE-1:0]   pending,
  output logic              err
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]     starve_cnt;
  grant_t            gnt;
  logic              alu_gnt, mem_gnt, xfer, clr, issue_set;
  logic [BITS-1:0]   win_dest;
  logic [WORD_W-1:0] win_data;
  logic [SIZE-1:0]   pend_nxt;
  logic              err_nxt;

  wb_grant u_grant (
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .starved   (starve_cnt == CW'(STARVE_LIMIT)),
    .gnt       (gnt)
  );

  // Grants are suppressed while reset is held so nothing transfers.
  assign alu_gnt   = (gnt == GNT_ALU) && reset;
  assign mem_gnt   = (gnt == GNT_MEM) && reset;
  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;
  assign xfer      = alu_gnt || mem_gnt;
  assign win_dest  = mem_gnt ? mem_dest : alu_dest;
  assign win_data  = mem_gnt ? mem_data : alu_data;
  assign clr       = xfer && (win_dest != '0);
  assign issue_set = issue_valid && (issue_dest != '0);

  // Set wins over clear; an issue that retires against a same-cycle write is legal.
  always_comb begin
    pend_nxt = pending;
    err_nxt  = err;
    if (clr) pend_nxt[win_dest] = 1'b0;
    if (issue_set) pend_nxt[issue_dest] = 1'b1;
    if (issue_set && pending[issue_dest] && !(clr && win_dest == issue_dest)) err_nxt = 1'b1;
    if (clr && !pending[win_dest]) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write   <= 1'b0;
      rf_dest    <= '0;
      rf_data    <= '0;
      pending    <= '0;
      err        <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rf_write <= clr;
      if (xfer) begin
        rf_dest <= win_dest;
        rf_data <= win_data;
      end
      pending <= pend_nxt;
      err     <= err_nxt;
      if (alu_valid && !alu_gnt)
        starve_cnt <= (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a negedge-capturing regfile model.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        alu_valid = 0, mem_valid = 0, issue_valid = 0;
  logic [4:0]  alu_dest = 0, mem_dest = 0, issue_dest = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic        alu_ready, mem_ready, rf_write, err;
  logic [4:0]  rf_dest;
  logic [31:0] rf_data, pending;
  logic [31:0] rf_model [0:31];
  int checks = 0, errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .rf_write(rf_write), .rf_dest(rf_dest), .rf_data(rf_data),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rf_write) rf_model[rf_dest] <= rf_data;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b0; #1;
    idle();
    tick(); reset = 1'b1;
  endtask

  initial begin
    logic [4:0] sched [0:5];
    sched[0] = 10; sched[1] = 11; sched[2] = 12; sched[3] = 13; sched[4] = 14; sched[5] = 14;
    #1 reset = 1'b0;
    alu_valid = 1; alu_dest = 3;
    #1;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_rf_write", rf_write, 0);
    chk("rst_rf_dest", rf_dest, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err", err, 0);
    idle();
    tick(); reset = 1'b1;
    tick();

    // ALU write to a pending register
    issue_valid = 1; issue_dest = 5; tick(); issue_valid = 0;
    chk("t2_pend_set", pending, 32'h20);
    alu_valid = 1; alu_dest = 5; alu_data = 32'hDEADBEEF; #1;
    chk("t2_alu_ready", alu_ready, 1);
    chk("t2_mem_ready", mem_ready, 0);
    tick(); alu_valid = 0;
    chk("t2_rf_write", rf_write, 1);
    chk("t2_rf_dest", rf_dest, 5);
    chk("t2_rf_data", rf_data, 32'hDEADBEEF);
    chk("t2_pend_clr", pending, 0);
    chk("t2_err", err, 0);
    tick();
    chk("t2_readA", rf_model[5], 32'hDEADBEEF);
    chk("t2_wr_drop", rf_write, 0);
    chk("t2_dest_hold", rf_dest, 5);

    // Reset mid-transfer
    issue_valid = 1; issue_dest = 6; tick();
    issue_dest = 5; alu_valid = 1; alu_dest = 6; alu_data = 32'h66; tick();
    idle();
    chk("t1_pre_write", rf_write, 1);
    chk("t1_pre_pend", pending, 32'h20);
    #2 reset = 1'b0; #1;
    chk("t1_write", rf_write, 0);
    chk("t1_pend", pending, 0);
    chk("t1_dest", rf_dest, 0);
    chk("t1_data", rf_data, 0);
    chk("t1_err", err, 0);
    tick(); reset = 1'b1;
    issue_valid = 1; issue_dest = 3; tick(); issue_valid = 0;
    alu_valid = 1; alu_dest = 3; alu_data = 32'h33; tick(); alu_valid = 0;
    chk("t1_post_write", rf_write, 1);
    chk("t1_post_dest", rf_dest, 3);
    chk("t1_post_err", err, 0);

    // Starvation guard
    for (int r = 10; r <= 15; r++) begin
      issue_valid = 1; issue_dest = 5'(r); tick();
    end
    issue_valid = 0;
    alu_valid = 1; alu_dest = 15; alu_data = 32'hA15;
    mem_valid = 1;
    for (int i = 0; i < 6; i++) begin
      mem_dest = sched[i]; mem_data = 32'h100 + 32'(sched[i]); #1;
      chk($sformatf("t3_mem_ready%0d", i), mem_ready, (i == 4) ? 0 : 1);
      chk($sformatf("t3_alu_ready%0d", i), alu_ready, (i == 4) ? 1 : 0);
      tick();
      chk($sformatf("t3_rf_dest%0d", i), rf_dest, (i == 4) ? 15 : 32'(sched[i]));
      if (i == 4) alu_valid = 0;
    end
    idle();
    chk("t3_pend", pending, 0);
    chk("t3_err", err, 0);

    // Write to register 0
    mem_valid = 1; mem_dest = 0; mem_data = 32'h1234; #1;
    chk("t4_mem_ready", mem_ready, 1);
    tick(); idle();
    chk("t4_rf_write", rf_write, 0);
    chk("t4_err", err, 0);
    chk("t4_pend", pending, 0);

    // Same-cycle set and clear of one register
    issue_valid = 1; issue_dest = 7; tick();
    mem_valid = 1; mem_dest = 7; mem_data = 32'h77; tick(); idle();
    chk("t5_pend", pending, 32'h80);
    chk("t5_rf_write", rf_write, 1);
    chk("t5_err", err, 0);
    mem_valid = 1; tick(); idle();
    chk("t5_pend_clr", pending, 0);

    // Write to a register with no outstanding issue
    alu_valid = 1; alu_dest = 20; alu_data = 32'h20; tick(); idle();
    chk("t7_err", err, 1);
    do_reset();
    chk("t7_err_rst", err, 0);

    // Double issue
    issue_valid = 1; issue_dest = 9; tick();
    chk("t6_err_first", err, 0);
    tick(); idle();
    chk("t6_err_second", err, 1);
    tick(); tick();
    chk("t6_err_sticky", err, 1);
    do_reset();
    chk("t6_err_rst", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
